// File: rtl/zap_async_event_arbiter.sv
// Asynchronous event collector: per-line synchronizer, rising-edge detect, pending latch,
// and a valid/ready grant port. Define ZAP_EVT_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.

module zap_dual_rank_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

module zap_async_event_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [N-1:0]  i_async_evt,
  input  logic [N-1:0]  i_mask,
  output logic          o_evt_valid,
  output logic [IW-1:0] o_evt_idx,
  input  logic          i_evt_ready,
  output logic [N-1:0]  o_pending,
  output logic [N-1:0]  o_overflow,
  input  logic [N-1:0]  i_clr_overflow
);

  localparam int unsigned NU = N;

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  w_sync;
  logic [N-1:0]  r_prev;
  logic [N-1:0]  w_edge;
  logic [N-1:0]  r_pend;
  logic [N-1:0]  r_ovf;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_elig;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_winner;
  logic          w_found;
  logic          w_accept;

  // Wrapping add used to walk the search order starting at the round-robin pointer.
  function automatic logic [IW-1:0] addMod(input logic [IW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NU) s = s - NU;
    return s[IW-1:0];
  endfunction

  zap_dual_rank_synchronizer #(
    .WIDTH (N)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_async_evt),
    .o_q     (w_sync)
  );

  assign w_edge = w_sync & ~r_prev;
  assign w_elig = r_pend & ~i_mask;
  assign w_clr  = w_accept ? ({{(N-1){1'b0}}, 1'b1} << r_idx) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_prev <= w_sync;
      r_pend <= w_edge | (r_pend & ~w_clr);
      r_ovf  <= (r_ovf & ~i_clr_overflow) | (w_edge & r_pend & ~w_clr);
    end
  end

`ifdef ZAP_EVT_ARB_FIXED_PRIORITY_EN
  assign w_base = '0;
`else
  logic [IW-1:0] r_rr_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  assign w_base = r_rr_ptr;
`endif

  // Scan from the far end so the line closest to w_base is the last (winning) assignment.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_elig[addMod(w_base, unsigned'(k))]) begin
        w_found  = 1'b1;
        w_winner = addMod(w_base, unsigned'(k));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_found) begin
        r_idx <= w_winner;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_next = S_OFFER;
      end
      S_OFFER: begin
        if (i_evt_ready) begin
          w_accept     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_evt_valid = (r_state == S_OFFER);
  assign o_evt_idx   = r_idx;
  assign o_pending   = r_pend;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_zap_async_event_arbiter.sv
// Self-checking bench for zap_async_event_arbiter (N=4): directed scenarios plus randomized
// traffic against a cycle-level reference model built from the event/arbitration rules.

module tb_zap_async_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  asyncEvt;
  logic [N-1:0]  mask;
  logic          ready;
  logic [N-1:0]  clrOvf;
  logic          evtValid;
  logic [IW-1:0] evtIdx;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  int compares = 0;
  int fails    = 0;

  // Reference model state: sampled-input history (oldest first), pending/overflow sets,
  // pointer, and the event currently offered.
  logic [N-1:0]  hist[$];
  logic [N-1:0]  mPend;
  logic [N-1:0]  mOvf;
  int            mPtr;
  bit            mOffer;
  logic [IW-1:0] mIdx;

  always #5 clk = ~clk;

  zap_async_event_arbiter #(.N(N)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_async_evt    (asyncEvt),
    .i_mask         (mask),
    .o_evt_valid    (evtValid),
    .o_evt_idx      (evtIdx),
    .i_evt_ready    (ready),
    .o_pending      (pending),
    .o_overflow     (overflow),
    .i_clr_overflow (clrOvf)
  );

  function automatic int pick(input logic [N-1:0] elig, input int from);
    for (int k = 0; k < N; k++) begin
      if (elig[(from + k) % N]) return (from + k) % N;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs that were stable before it.
  task automatic modelStep();
    logic [N-1:0] rise;
    logic [N-1:0] taken;
    logic [N-1:0] elig;
    logic [N-1:0] one;
    if (reset) begin
      hist = {};
      repeat (3) hist.push_back('0);
      mPend  = '0;
      mOvf   = '0;
      mPtr   = 0;
      mOffer = 1'b0;
      mIdx   = '0;
    end else begin
      one   = 1;
      rise  = hist[1] & ~hist[0];
      taken = (mOffer && ready) ? (one << mIdx) : '0;
      elig  = mPend & ~mask;
      if (mOffer) begin
        if (ready) begin
          mOffer = 1'b0;
`ifndef ZAP_EVT_ARB_FIXED_PRIORITY_EN
          mPtr = (int'(mIdx) + 1) % N;
`endif
        end
      end else if (elig != '0) begin
`ifdef ZAP_EVT_ARB_FIXED_PRIORITY_EN
        mIdx = IW'(pick(elig, 0));
`else
        mIdx = IW'(pick(elig, mPtr));
`endif
        mOffer = 1'b1;
      end
      mOvf  = (mOvf & ~clrOvf) | (rise & mPend & ~taken);
      mPend = rise | (mPend & ~taken);
      void'(hist.pop_front());
      hist.push_back(asyncEvt);
    end
  endtask

  task automatic checkEq(input string tag, input int observed, input int expected);
    compares++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    compares++;
    assert (evtValid === logic'(mOffer)) else begin
      fails++;
      $error("FAIL %s valid observed=%0b expected=%0b", tag, evtValid, mOffer);
    end
    compares++;
    assert (evtIdx === mIdx) else begin
      fails++;
      $error("FAIL %s idx observed=%0d expected=%0d", tag, evtIdx, mIdx);
    end
    compares++;
    assert (pending === mPend) else begin
      fails++;
      $error("FAIL %s pending observed=%b expected=%b", tag, pending, mPend);
    end
    compares++;
    assert (overflow === mOvf) else begin
      fails++;
      $error("FAIL %s overflow observed=%b expected=%b", tag, overflow, mOvf);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] evt, input logic [N-1:0] msk, input logic rdy,
                               input logic [N-1:0] clro, input logic rst, input string tag);
    asyncEvt = evt;
    mask     = msk;
    ready    = rdy;
    clrOvf   = clro;
    reset    = rst;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int lat;
    int offers;
    int grants[$];
    int gcyc[$];
    int expG[3];
    logic [N-1:0] evtR;
    logic [N-1:0] mskR;

    repeat (3) hist.push_back('0);
    mPend = '0; mOvf = '0; mPtr = 0; mOffer = 1'b0; mIdx = '0;
    asyncEvt = '0; mask = '0; ready = 1'b0; clrOvf = '0; reset = 1'b1;
    #1;

    // Reset state
    repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, "reset");
    checkEq("resetValid", int'(evtValid), 0);
    checkEq("resetIdx", int'(evtIdx), 0);
    checkEq("resetPending", int'(pending), 0);
    checkEq("resetOverflow", int'(overflow), 0);

    // Single event on line 2: offered after the 4th edge, one acceptance only
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, "single");
      if (evtValid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkEq("singleLatency", lat, 4);
    checkEq("singleIdx", int'(evtIdx), 2);
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, "singleAccept");
    checkEq("singleCleared", int'(pending), 0);
    offers = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, "singleQuiet");
      if (evtValid === 1'b1) offers++;
    end
    checkEq("singleNoReoffer", offers, 0);

    // Round-robin: lines 0,1,3 together, ready tied high
    applyStimulus(4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b1, "rrReset");
    for (int c = 0; c < 14; c++) begin
      if (evtValid === 1'b1) begin
        grants.push_back(int'(evtIdx));
        gcyc.push_back(c);
      end
      applyStimulus(4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0, "rr");
    end
    expG = '{0, 1, 3};
    checkEq("rrCount", grants.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkEq($sformatf("rrGrant%0d", i), (i < grants.size()) ? grants[i] : -1, expG[i]);
    end
    for (int i = 1; i < 3; i++) begin
      checkEq($sformatf("rrGap%0d", i), (i < gcyc.size()) ? gcyc[i] - gcyc[i-1] : -1, 2);
    end
    // Pointer wrapped to 0: with lines 0 and 2 pending, line 0 wins first
    repeat (4) applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "rrLow");
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, "rrWrap");
      if (evtValid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkEq("rrWrapSeen", lat, 4);
    checkEq("rrWrapIdx", int'(evtIdx), 0);

    // Mask holds line 1 pending without an offer; unmasking offers it on the next IDLE cycle
    applyStimulus(4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b1, "maskReset");
    repeat (8) applyStimulus(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, "masked");
    checkEq("maskPending", int'(pending), 2);
    checkEq("maskNoOffer", int'(evtValid), 0);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, "unmask");
    checkEq("unmaskValid", int'(evtValid), 1);
    checkEq("unmaskIdx", int'(evtIdx), 1);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, "unmaskAccept");

    // Overflow on line 0, write-1-to-clear, and set-wins on acceptance
    applyStimulus(4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1, "ovfReset");
    repeat (4) applyStimulus(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "ovfHigh1");
    repeat (4) applyStimulus(4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, "ovfLow");
    repeat (4) applyStimulus(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "ovfHigh2");
    checkEq("ovfSet", int'(overflow), 1);
    applyStimulus(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, "ovfClear");
    checkEq("ovfCleared", int'(overflow), 0);
    repeat (4) applyStimulus(4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, "ovfLow2");
    repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "ovfOffer");
    checkEq("ovfOfferIdx", int'(evtIdx), 0);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, "setWins0");
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, "setWins1");
    applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, "setWinsAccept");
    checkEq("setWinsPending", int'(pending[0]), 1);
    checkEq("setWinsOvf", int'(overflow), 0);

    // Reset during an offer of line 3 with the line still high
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, "midReset0");
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, "midWait");
      if (evtValid === 1'b1) break;
    end
    checkEq("midOfferIdx", int'(evtIdx), 3);
    applyStimulus(4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b1, "midReset");
    checkEq("midValid", int'(evtValid), 0);
    checkEq("midPending", int'(pending), 0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, "midRelease");
      if (evtValid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkEq("midLatency", lat, 4);
    checkEq("midIdx", int'(evtIdx), 3);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, "midAccept");
    offers = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, "midQuiet");
      if (evtValid === 1'b1) offers++;
    end
    checkEq("midSingleOffer", offers, 0);

`ifdef ZAP_EVT_ARB_FIXED_PRIORITY_EN
    // Lines 1 and 3 kept re-pending; line 1 must win whenever both are eligible
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, "fixedReset");
    for (int c = 0; c < 60; c++) begin
      evtR = ((c / 3) % 2 == 0) ? 4'b1010 : 4'b0000;
      applyStimulus(evtR, 4'b0000, 1'b1, 4'b0000, 1'b0, "fixed");
    end
`endif

    // Randomized traffic against the model
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, "rndReset");
    evtR = '0;
    mskR = '0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) evtR[b] = ~evtR[b];
      end
      if (c % 16 == 0) mskR = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      applyStimulus(evtR, mskR, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0,
                    ($urandom_range(0, 99) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
